mul_controller: RTL and testbench

Sequencing controller for the repeated-addition multiplier datapath. It drives the datapath's load, clear and decrement strobes (`LdA`, `LdB`, `LdP`, `clrP`, `decB`) and consumes its `eqz` flag. It runs one start/done transaction per multiplication: it steers the two operands from the shared `data_in` bus, then iterates until the B counter reaches zero. It sits directly upstream of the datapath in the control path, and it also counts the add iterations and supports abort.

---
 rtl/mul_controller.sv | 115 +++++++++++
 tb/tb_mul_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_controller.sv
// Sequencing controller for the repeated-addition multiplier datapath.
// Loads A then B from the shared bus, accumulates P+A until B reaches zero, counts iterations.
`timescale 1ns/1ps

module mul_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             eqz,
    output logic             LdA,
    output logic             LdB,
    output logic             LdP,
    output logic             clrP,
    output logic             decB,
    output logic             op_sel,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] ITER_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ADD,
        DONE
    } state_t;

    state_t state;
    state_t nextState;
    logic   abortTake;

    assign abortTake = abort && (state != IDLE);

    // State register, abort pulse and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aborted  <= 1'b0;
            iter_cnt <= '0;
        end else begin
            state   <= nextState;
            aborted <= abortTake;
            if (LdB) begin
                iter_cnt <= '0;
            end else if (LdP && (iter_cnt != ITER_MAX)) begin
                iter_cnt <= iter_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode; strobes are already gated by abort, so the
    // counter can key off LdB/LdP directly and holds its value on abort.
    always_comb begin
        nextState = state;
        LdA       = 1'b0;
        LdB       = 1'b0;
        LdP       = 1'b0;
        clrP      = 1'b0;
        decB      = 1'b0;
        op_sel    = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    nextState = LOAD_A;
                end
            end
            LOAD_A: begin
                LdA       = 1'b1;
                nextState = LOAD_B;
            end
            LOAD_B: begin
                LdB       = 1'b1;
                clrP      = 1'b1;
                op_sel    = 1'b1;
                nextState = ADD;
            end
            ADD: begin
                if (!eqz) begin
                    LdP  = 1'b1;
                    decB = 1'b1;
                end else begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        if (abortTake) begin
            nextState = IDLE;
            LdA       = 1'b0;
            LdB       = 1'b0;
            LdP       = 1'b0;
            clrP      = 1'b0;
            decB      = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_controller.sv
// Bench for mul_controller: behavioural datapath plus directed and randomized operations
// checked against product, latency and iteration-count expectations.
`timescale 1ns/1ps

module tb_mul_controller;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             eqz;
    logic             LdA, LdB, LdP, clrP, decB, op_sel, busy, done, aborted;
    logic [CNT_W-1:0] iter_cnt;

    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic [15:0] dataIn;
    logic [15:0] aReg = '0;
    logic [15:0] bReg = '0;
    logic [15:0] pReg = '0;

    int checks = 0;
    int errors = 0;
    int lastIter = 0;

    mul_controller #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .eqz      (eqz),
        .LdA      (LdA),
        .LdB      (LdB),
        .LdP      (LdP),
        .clrP     (clrP),
        .decB     (decB),
        .op_sel   (op_sel),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    // Upstream source and repeated-addition datapath
    assign dataIn = op_sel ? opB : opA;
    assign eqz    = (bReg == 16'd0);

    always @(posedge clk) begin
        if (LdA) aReg <= dataIn;
        if (LdB) bReg <= dataIn;
        else if (decB) bReg <= bReg - 16'd1;
        if (clrP) pReg <= '0;
        else if (LdP) pReg <= pReg + aReg;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation; abortCyc = 0 means run to completion, else abort in that cycle
    // (cycle 1 = LOAD_A). Returns sampling the IDLE cycle that follows.
    task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                         input int abortCyc, input bit hold);
        int cyc;
        int ldp;
        int doneCyc;
        int abortSeenCyc;
        int expIter;
        int prod;
        opA   = a;
        opB   = b;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        cyc          = 1;
        ldp          = 0;
        doneCyc      = -1;
        abortSeenCyc = -1;
        while (cyc <= int'(b) + 10) begin
            if (cyc == 1) begin
                check("loadA_LdA", 32'(LdA), 1);
                check("loadA_opsel", 32'(op_sel), 0);
                check("loadA_busy", 32'(busy), 1);
            end
            if (cyc == 2 && abortCyc != 1) begin
                check("loadB_LdB_clrP", 32'({LdB, clrP}), 3);
                check("loadB_opsel", 32'(op_sel), 1);
            end
            if (cyc == abortCyc) begin
                abort = 1'b1;
                #1;
                check("abort_strobes", 32'({LdA, LdB, LdP, clrP, decB, done}), 0);
            end
            if (LdP) ldp++;
            if (done) begin
                doneCyc = cyc;
                break;
            end
            if (aborted) begin
                abortSeenCyc = cyc;
                break;
            end
            step();
            abort = 1'b0;
            cyc++;
        end

        if (abortCyc == 0) begin
            prod = (int'(a) * int'(b)) & 32'hFFFF;
            check("done_latency", 32'(doneCyc), 32'(int'(b) + 4));
            check("product", 32'(pReg), 32'(prod));
            check("iter_done", 32'(iter_cnt), 32'(b));
            check("ldp_count", 32'(ldp), 32'(b));
            lastIter = int'(b);
            step();
            check("idle_after_done", 32'({busy, done, aborted}), 0);
        end else begin
            expIter = (abortCyc <= 2) ? lastIter : abortCyc - 3;
            check("aborted_cycle", 32'(abortSeenCyc), 32'(abortCyc + 1));
            check("abort_idle", 32'({busy, done}), 0);
            check("abort_iter", 32'(iter_cnt), 32'(expIter));
            lastIter = expIter;
            step();
            check("aborted_one_pulse", 32'({aborted, done}), 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        step();
        step();
        check("reset_outputs",
              32'({LdA, LdB, LdP, clrP, decB, op_sel, busy, done, aborted}), 0);
        check("reset_iter", 32'(iter_cnt), 0);
        rst = 1'b0;
        step();
        check("idle_stays", 32'(busy), 0);

        // Directed operations
        runOp(16'd5, 16'd3, 0, 1'b0);
        runOp(16'd9, 16'd0, 0, 1'b0);
        runOp(16'h0100, 16'h0200, 0, 1'b0);
        runOp(16'd4, 16'd10, 4, 1'b0);
        runOp(16'd2, 16'd2, 0, 1'b0);
        runOp(16'd7, 16'd3, 1, 1'b0);

        // start held high: back-to-back with a single IDLE cycle between
        runOp(16'd3, 16'd2, 0, 1'b1);
        runOp(16'd7, 16'd1, 0, 1'b1);
        start = 1'b0;

        // Reset in the middle of ADD with start held high
        opA   = 16'd5;
        opB   = 16'd6;
        start = 1'b1;
        step();
        repeat (4) step();
        check("pre_reset_in_add", 32'(LdP), 1);
        rst = 1'b1;
        step();
        check("rst_outputs",
              32'({LdA, LdB, LdP, clrP, decB, op_sel, busy, done, aborted}), 0);
        check("rst_iter", 32'(iter_cnt), 0);
        rst      = 1'b0;
        lastIter = 0;
        runOp(16'd5, 16'd6, 0, 1'b0);

        // Randomized operations, some aborted
        for (int i = 0; i < 12; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            int          ac;
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, 12));
            ac = 0;
            if ($urandom_range(0, 3) == 0) ac = int'($urandom_range(1, int'(rb) + 2));
            runOp(ra, rb, ac, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
